// File: rtl/key_switch_device.sv
// Memory-mapped KEY/SW input peripheral: synchronised, debounced inputs exposed as
// DATA registers, with READY/OVERRUN/IE control registers and a registered interrupt.
module key_switch_chan #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNTBITS         = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pins,
  input  logic         rd_data,
  input  logic         wr_ctrl,
  input  logic         wr_ovr,
  input  logic         wr_ie,
  output logic [W-1:0] stable,
  output logic         ready,
  output logic         overrun,
  output logic         ie
);
  logic [W-1:0]       meta;
  logic [W-1:0]       synced;
  logic [CNTBITS-1:0] cnt;
  logic               change;

  // The whole vector must differ from the accepted value for DEBOUNCE_CYCLES edges in a row.
  assign change = (synced != stable) && (cnt == CNTBITS'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= '0;
      synced  <= '0;
      cnt     <= '0;
      stable  <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      meta   <= pins;
      synced <= meta;

      if (synced == stable) begin
        cnt <= '0;
      end else if (change) begin
        cnt    <= '0;
        stable <= synced;
      end else begin
        cnt <= cnt + CNTBITS'(1);
      end

      // A new event beats a clearing read on the same edge.
      if (change) begin
        ready <= 1'b1;
      end else if (rd_data) begin
        ready <= 1'b0;
      end

      // Setting OVERRUN beats a software clear on the same edge.
      if (change && ready && !rd_data) begin
        overrun <= 1'b1;
      end else if (wr_ctrl && !wr_ovr) begin
        overrun <= 1'b0;
      end

      if (wr_ctrl) begin
        ie <= wr_ie;
      end
    end
  end
endmodule

module key_switch_device #(
  parameter int                DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDRKEY         = 32'hFFFFF080,
  parameter logic [DBITS-1:0]  ADDRSW          = 32'hFFFFF090,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter int                CNTBITS         = 20
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrdata,
  input  logic             we,
  input  logic             re,
  output logic             sel,
  output logic [DBITS-1:0] rddata,
  output logic             irq
);
  localparam logic [DBITS-1:0] KCTRL_ADDR = ADDRKEY + DBITS'(4);
  localparam logic [DBITS-1:0] SCTRL_ADDR = ADDRSW + DBITS'(4);

  logic       hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
  logic [3:0] key_stable;
  logic [9:0] sw_stable;
  logic       key_ready, key_ovr, key_ie;
  logic       sw_ready, sw_ovr, sw_ie;
  logic       unused;

  assign hit_kdata = (addr == ADDRKEY);
  assign hit_kctrl = (addr == KCTRL_ADDR);
  assign hit_sdata = (addr == ADDRSW);
  assign hit_sctrl = (addr == SCTRL_ADDR);
  assign sel       = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;
  assign unused    = ^{wrdata[DBITS-1:9], wrdata[7:3], wrdata[1:0]};

  // Buttons are active-low on the pins; invert so a pressed key reads 1.
  key_switch_chan #(
    .W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS)
  ) u_key (
    .clk(clk), .rst_n(RESET_N), .pins(~KEY),
    .rd_data(re && hit_kdata), .wr_ctrl(we && hit_kctrl),
    .wr_ovr(wrdata[2]), .wr_ie(wrdata[8]),
    .stable(key_stable), .ready(key_ready), .overrun(key_ovr), .ie(key_ie)
  );

  key_switch_chan #(
    .W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS)
  ) u_sw (
    .clk(clk), .rst_n(RESET_N), .pins(SW),
    .rd_data(re && hit_sdata), .wr_ctrl(we && hit_sctrl),
    .wr_ovr(wrdata[2]), .wr_ie(wrdata[8]),
    .stable(sw_stable), .ready(sw_ready), .overrun(sw_ovr), .ie(sw_ie)
  );

  always_comb begin
    rddata = '0;
    if (hit_kdata) begin
      rddata = DBITS'(key_stable);
    end else if (hit_kctrl) begin
      rddata = DBITS'({key_ie, 5'b0, key_ovr, 1'b0, key_ready});
    end else if (hit_sdata) begin
      rddata = DBITS'(sw_stable);
    end else if (hit_sctrl) begin
      rddata = DBITS'({sw_ie, 5'b0, sw_ovr, 1'b0, sw_ready});
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      irq <= 1'b0;
    end else begin
      irq <= (key_ready & key_ie) | (sw_ready & sw_ie);
    end
  end
endmodule

// File: tb/tb_key_switch_device.sv
// Bench for key_switch_device: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a history-based reference model.
module tb_key_switch_device;
  localparam int D = 4;
  localparam logic [31:0] AK  = 32'hFFFFF080;
  localparam logic [31:0] AKC = 32'hFFFFF084;
  localparam logic [31:0] AS  = 32'hFFFFF090;
  localparam logic [31:0] ASC = 32'hFFFFF094;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key = 4'hF;
  logic [9:0]  sw = 10'h0;
  logic [31:0] addr = 32'hFFFFF000;
  logic [31:0] wrdata = 32'h0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        sel;
  logic        irq;
  logic [31:0] rddata;

  int total = 0;
  int bad = 0;

  key_switch_device #(.DEBOUNCE_CYCLES(D), .CNTBITS(3)) dut (
    .clk(clk), .RESET_N(rst_n), .KEY(key), .SW(sw), .addr(addr), .wrdata(wrdata),
    .we(we), .re(re), .sel(sel), .rddata(rddata), .irq(irq)
  );

  always #10 clk = ~clk;

  // Reference model: pin history per device, indexed by edge number.
  logic [9:0] m_stable [2];
  logic       m_ready  [2];
  logic       m_ovr    [2];
  logic       m_ie     [2];
  logic       m_irq;
  logic [9:0] ph [2][0:63];
  int         edge_no = 0;
  int         last_upd [2];
  logic [9:0] m_pins [2];
  logic       m_rd [2];
  logic       m_wr [2];
  logic       ev;
  logic       irq_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_stable[d] = '0;
        m_ready[d]  = 1'b0;
        m_ovr[d]    = 1'b0;
        m_ie[d]     = 1'b0;
        ph[d][edge_no & 63]       = '0;
        ph[d][(edge_no - 1) & 63] = '0;
        last_upd[d] = edge_no;
      end
      m_irq = 1'b0;
    end else begin
      edge_no++;
      irq_n = (m_ready[0] & m_ie[0]) | (m_ready[1] & m_ie[1]);
      m_pins[0] = {6'b0, ~key};
      m_pins[1] = sw;
      m_rd[0] = re && (addr == AK);
      m_rd[1] = re && (addr == AS);
      m_wr[0] = we && (addr == AKC);
      m_wr[1] = we && (addr == ASC);
      for (int d = 0; d < 2; d++) begin
        // Accepted when the values seen by the debouncer (pins two edges late) differed
        // from the accepted value on each of the last D edges since the previous update.
        ev = (edge_no - last_upd[d]) >= D;
        for (int j = 0; j < D; j++)
          if (ph[d][(edge_no - 2 - j) & 63] == m_stable[d]) ev = 1'b0;
        if (ev && m_ready[d] && !m_rd[d]) m_ovr[d] = 1'b1;
        else if (m_wr[d] && !wrdata[2]) m_ovr[d] = 1'b0;
        if (ev) m_ready[d] = 1'b1;
        else if (m_rd[d]) m_ready[d] = 1'b0;
        if (m_wr[d]) m_ie[d] = wrdata[8];
        if (ev) begin
          m_stable[d] = ph[d][(edge_no - 2) & 63];
          last_upd[d] = edge_no;
        end
        ph[d][edge_no & 63] = m_pins[d];
      end
      m_irq = irq_n;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == AK)  return {22'b0, m_stable[0]};
    if (a == AKC) return {23'b0, m_ie[0], 5'b0, m_ovr[0], 1'b0, m_ready[0]};
    if (a == AS)  return {22'b0, m_stable[1]};
    if (a == ASC) return {23'b0, m_ie[1], 5'b0, m_ovr[1], 1'b0, m_ready[1]};
    return 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("sel", {31'b0, sel}, {31'b0, (addr == AK) || (addr == AKC) || (addr == AS) || (addr == ASC)});
    chk("rddata", rddata, exp_rd(addr));
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rddata, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_sel", {31'b0, sel}, 32'h0);
    chk("rst_rddata", rddata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd_chk("rst_kdata", AK, 32'h0);
    rd_chk("rst_kctrl", AKC, 32'h0);
    rd_chk("rst_sdata", AS, 32'h0);

    // Key press: accepted on the sixth edge after the pin change
    step(1);
    key = 4'hE;
    step(5);
    rd_chk("kdata_early", AK, 32'h0);
    step(1);
    rd_chk("kdata_press", AK, 32'h1);
    rd_chk("kctrl_ready", AKC, 32'h1);
    addr = AK;
    re = 1'b1;
    #1;
    chk("kdata_read", rddata, 32'h1);
    step(1);
    re = 1'b0;
    rd_chk("kctrl_cleared", AKC, 32'h0);

    // Glitch of 3 cycles rejected, then a held change accepted
    sw = 10'h008;
    step(3);
    sw = 10'h000;
    step(8);
    rd_chk("glitch_sdata", AS, 32'h0);
    rd_chk("glitch_sctrl", ASC, 32'h0);
    sw = 10'h008;
    step(6);
    rd_chk("sw_sdata", AS, 32'h8);
    rd_chk("sw_sctrl", ASC, 32'h1);

    // Overrun and interrupt enable
    key = 4'hC;
    step(6);
    rd_chk("ovr_kdata1", AK, 32'h3);
    rd_chk("ovr_kctrl1", AKC, 32'h1);
    key = 4'h8;
    step(6);
    rd_chk("ovr_kdata2", AK, 32'h7);
    rd_chk("ovr_kctrl2", AKC, 32'h5);
    addr = AKC;
    wrdata = 32'h104;
    we = 1'b1;
    step(1);
    we = 1'b0;
    rd_chk("ie_kctrl", AKC, 32'h105);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    step(1);
    #1;
    chk("irq_set", {31'b0, irq}, 32'h1);
    addr = AKC;
    wrdata = 32'h100;
    we = 1'b1;
    step(1);
    we = 1'b0;
    rd_chk("ovr_clear", AKC, 32'h101);
    addr = AK;
    re = 1'b1;
    #1;
    chk("ovr_read", rddata, 32'h7);
    step(1);
    re = 1'b0;
    rd_chk("read_kctrl", AKC, 32'h100);
    step(1);
    #1;
    chk("irq_drop", {31'b0, irq}, 32'h0);

    // Read on the same edge as the change event
    key = 4'hF;
    step(5);
    addr = AK;
    re = 1'b1;
    #1;
    chk("simul_old", rddata, 32'h7);
    step(1);
    re = 1'b0;
    rd_chk("simul_kdata", AK, 32'h0);
    rd_chk("simul_kctrl", AKC, 32'h101);

    // Asynchronous reset in the middle of a debounce count
    sw = 10'h010;
    step(6);
    rd_chk("sw_ovr", ASC, 32'h5);
    addr = ASC;
    wrdata = 32'h104;
    we = 1'b1;
    step(1);
    we = 1'b0;
    rd_chk("sctrl_105", ASC, 32'h105);
    sw = 10'h020;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("async_sctrl", rddata, 32'h0);
    chk("async_irq", {31'b0, irq}, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(5);
    rd_chk("restart_early", AS, 32'h0);
    step(1);
    rd_chk("restart_sdata", AS, 32'h20);
    rd_chk("restart_sctrl", ASC, 32'h1);

    // Randomized traffic checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) key = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
      case ($urandom_range(0, 5))
        0: addr = AK;
        1: addr = AKC;
        2: addr = AS;
        3: addr = ASC;
        4: addr = AK + 32'd8;
        default: addr = $urandom;
      endcase
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 2) == 0);
      wrdata = $urandom;
      rst_n = ($urandom_range(0, 999) != 0);
      step(1);
    end
    rst_n = 1'b1;
    we = 1'b0;
    re = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
